color_calib_timer: RTL and testbench

- Parametrised successor to the sensor white-balance timer. Steps the colour sensor's photodiode filter through up to four channels.
- For each channel, measures how many clk cycles the sensor frequency output takes to produce PULSE_COUNT rising edges. Results feed the colour-scaling logic.
- Additions over the previous generation:
  - synchronised sensor input;
  - start/ready handshake, so calibration can be re-run;
  - a filter settle period;
  - a per-channel timeout.

---
 rtl/color_calib_timer.sv | 189 ++++++++++++++++++
 tb/tb_color_calib_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_calib_timer.sv
// Colour-sensor calibration timer: steps the photodiode filter through up to four
// channels and times PULSE_COUNT sensor edges on each, with settle, watchdog and handshake.
module color_calib_timer #(
  parameter int         NUM_CH         = 3,
  parameter logic [7:0] FILTER_SEQ     = 8'hAC,
  parameter int         PULSE_COUNT    = 256,
  parameter int         TIME_W         = 32,
  parameter int         SETTLE_CYCLES  = 64,
  parameter int         TIMEOUT_CYCLES = 16777216
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     freq_in,
  output logic [1:0]               filter_select,
  output logic                     busy,
  output logic                     done,
  output logic                     ready,
  output logic [NUM_CH*TIME_W-1:0] ch_time,
  output logic [NUM_CH-1:0]        ch_timeout
);

  localparam int EC_W = $clog2(PULSE_COUNT + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ARM, S_MEASURE} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic                sync_edge;
  logic [1:0]          ch_q, ch_d;
  logic [ST_W-1:0]     settle_q, settle_d;
  logic [EC_W-1:0]     ecnt_q, ecnt_d;
  logic [TIME_W-1:0]   tcnt_q, tcnt_d;
  logic [TIME_W-1:0]   wdog_q, wdog_d;
  logic [1:0]          fsel_q, fsel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [TIME_W-1:0]   time_q [NUM_CH];
  logic [TIME_W-1:0]   time_d [NUM_CH];
  logic [NUM_CH-1:0]   tout_q, tout_d;
  logic                finish_ch;
  logic                timed_out;
  logic [TIME_W-1:0]   result;

  function automatic logic [1:0] code_for(input logic [1:0] c);
    return FILTER_SEQ[{c, 1'b0} +: 2];
  endfunction

  assign sync_edge = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    settle_d  = settle_q;
    ecnt_d    = ecnt_q;
    tcnt_d    = tcnt_q;
    wdog_d    = wdog_q;
    fsel_d    = fsel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    time_d    = time_q;
    tout_d    = tout_q;
    finish_ch = 1'b0;
    timed_out = 1'b0;
    result    = '0;

    case (state_q)
      S_IDLE: begin
        fsel_d = FILTER_SEQ[1:0];
        if (start) begin
          for (int i = 0; i < NUM_CH; i++) time_d[i] = '0;
          tout_d   = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          ch_d     = 2'd0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
          wdog_d  = '0;
          state_d = S_ARM;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      S_ARM: begin
        wdog_d = wdog_q + TIME_W'(1);
        if (sync_edge) begin
          tcnt_d  = '0;
          ecnt_d  = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        wdog_d = wdog_q + TIME_W'(1);
        tcnt_d = tcnt_q + TIME_W'(1);
        if (sync_edge) begin
          ecnt_d = ecnt_q + EC_W'(1);
          if (ecnt_q == EC_W'(PULSE_COUNT - 1)) begin
            finish_ch = 1'b1;
            result    = tcnt_q + TIME_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog overrides a final edge arriving on the same cycle.
    if ((state_q == S_ARM || state_q == S_MEASURE) &&
        wdog_q == TIME_W'(TIMEOUT_CYCLES - 1)) begin
      finish_ch = 1'b1;
      timed_out = 1'b1;
      result    = '1;
    end

    if (finish_ch) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_q == 2'(i)) begin
          time_d[i] = result;
          if (timed_out) tout_d[i] = 1'b1;
        end
      end
      if (ch_q == 2'(NUM_CH - 1)) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        done_d  = 1'b1;
        fsel_d  = FILTER_SEQ[1:0];
      end else begin
        ch_d     = ch_q + 2'd1;
        settle_d = '0;
        state_d  = S_SETTLE;
        fsel_d   = code_for(ch_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= S_IDLE;
      ch_q     <= 2'd0;
      settle_q <= '0;
      ecnt_q   <= '0;
      tcnt_q   <= '0;
      wdog_q   <= '0;
      fsel_q   <= FILTER_SEQ[1:0];
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      tout_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) time_q[i] <= '0;
    end else begin
      s1_q     <= freq_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
      ecnt_q   <= ecnt_d;
      tcnt_q   <= tcnt_d;
      wdog_q   <= wdog_d;
      fsel_q   <= fsel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      tout_q   <= tout_d;
      for (int i = 0; i < NUM_CH; i++) time_q[i] <= time_d[i];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
    assign ch_time[gi*TIME_W +: TIME_W] = time_q[gi];
  end

  assign filter_select = fsel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ready         = ready_q;
  assign ch_timeout    = tout_q;

endmodule

// File: tb/tb_color_calib_timer.sv
// Directed bench for color_calib_timer: nominal, timeout, settle masking, handshake, reset.
module tb_color_calib_timer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        freq_in;
  logic [1:0]  filter_select;
  logic        busy, done, ready;
  logic [95:0] ch_time;
  logic [2:0]  ch_timeout;

  int total = 0;
  int bad   = 0;

  color_calib_timer #(
    .NUM_CH(3), .FILTER_SEQ(8'hAC), .PULSE_COUNT(8), .TIME_W(32),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .freq_in(freq_in),
    .filter_select(filter_select), .busy(busy), .done(done), .ready(ready),
    .ch_time(ch_time), .ch_timeout(ch_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor model: period follows the filter code unless force_p >= 0; kill_g silences green.
  int force_p = -1;
  bit kill_g  = 1'b0;
  int cur_p   = 0;
  int ph      = 0;

  initial begin
    int p;
    freq_in = 1'b0;
    forever begin
      @(negedge clk);
      if (force_p >= 0) p = force_p;
      else begin
        case (filter_select)
          2'b00:   p = 10;
          2'b11:   p = kill_g ? 0 : 14;
          2'b10:   p = 6;
          default: p = 0;
        endcase
      end
      if (p != cur_p) begin
        cur_p = p;
        ph    = 0;
      end
      if (cur_p == 0) freq_in = 1'b0;
      else begin
        freq_in = (ph < cur_p / 2);
        ph      = (ph + 1) % cur_p;
      end
    end
  end

  int         cyc      = 0;
  int         done_cnt = 0;
  logic [1:0] fs_log[$];
  int         fs_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (fs_log.size() == 0 || filter_select != fs_log[fs_log.size()-1]) begin
        fs_log.push_back(filter_select);
        fs_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check_eq({tag, "_done_seen"}, {63'd0, done}, 64'd1);
  endtask

  task automatic check_results(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [2:0] eto);
    check_eq({tag, "_ch0"}, {32'd0, ch_time[31:0]}, {32'd0, e0});
    check_eq({tag, "_ch1"}, {32'd0, ch_time[63:32]}, {32'd0, e1});
    check_eq({tag, "_ch2"}, {32'd0, ch_time[95:64]}, {32'd0, e2});
    check_eq({tag, "_tout"}, {61'd0, ch_timeout}, {61'd0, eto});
    check_eq({tag, "_ready"}, {63'd0, ready}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_ready"}, {63'd0, ready}, 64'd0);
    check_eq({tag, "_time"}, {32'd0, ch_time[95:64] | ch_time[63:32] | ch_time[31:0]}, 64'd0);
    check_eq({tag, "_tout"}, {61'd0, ch_timeout}, 64'd0);
    check_eq({tag, "_fsel"}, {62'd0, filter_select}, 64'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal run
    done_cnt = 0;
    fs_log.delete();
    fs_cyc.delete();
    do_start();
    @(negedge clk);
    check_eq("nom_busy", {63'd0, busy}, 64'd1);
    wait_done("nom", 1000);
    check_eq("nom_busy_end", {63'd0, busy}, 64'd0);
    check_results("nom", 32'd80, 32'd112, 32'd48, 3'b000);
    @(negedge clk);
    check_eq("nom_done_1cyc", {63'd0, done}, 64'd0);
    check_eq("nom_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("nom_fs_len", 64'(fs_log.size()), 64'd4);
    if (fs_log.size() == 4) begin
      check_eq("nom_fs0", {62'd0, fs_log[0]}, 64'd0);
      check_eq("nom_fs1", {62'd0, fs_log[1]}, 64'd3);
      check_eq("nom_fs2", {62'd0, fs_log[2]}, 64'd2);
      check_eq("nom_fs3", {62'd0, fs_log[3]}, 64'd0);
    end

    // Start pulsed mid-run must be ignored
    done_cnt = 0;
    do_start();
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid", 1000);
    check_results("mid", 32'd80, 32'd112, 32'd48, 3'b000);
    repeat (3) @(negedge clk);
    check_eq("mid_done_cnt", 64'(done_cnt), 64'd1);

    // Start held high: re-triggers the cycle after done and clears ready
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    wait_done("hold1", 1000);
    check_eq("hold1_ready", {63'd0, ready}, 64'd1);
    check_eq("hold1_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_eq("retrig_busy", {63'd0, busy}, 64'd1);
    check_eq("retrig_ready", {63'd0, ready}, 64'd0);
    check_eq("retrig_done", {63'd0, done}, 64'd0);
    start = 1'b0;
    wait_done("hold2", 1000);
    check_results("hold2", 32'd80, 32'd112, 32'd48, 3'b000);

    // Green channel silent: watchdog fires 200 cycles after ARM (4 settle + 200)
    repeat (3) @(negedge clk);
    kill_g = 1'b1;
    fs_log.delete();
    fs_cyc.delete();
    do_start();
    wait_done("tmo", 2000);
    check_results("tmo", 32'd80, 32'hFFFF_FFFF, 32'd48, 3'b010);
    @(negedge clk);
    check_eq("tmo_fs_len", 64'(fs_log.size()), 64'd4);
    if (fs_log.size() == 4)
      check_eq("tmo_ch1_span", 64'(fs_cyc[2] - fs_cyc[1]), 64'd204);
    kill_g = 1'b0;

    // Fast edges only during SETTLE must not be counted
    force_p = 2;
    repeat (6) @(negedge clk);
    do_start();
    @(posedge clk);
    #1 force_p = 10;
    wait_done("settle", 1000);
    check_results("settle", 32'd80, 32'd80, 32'd80, 3'b000);
    force_p = -1;
    repeat (3) @(negedge clk);

    // Reset while measuring channel 1
    do_start();
    n = 0;
    while (filter_select !== 2'b11 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_ch1", {62'd0, filter_select}, 64'd3);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    check_eq("midrst_idle", {63'd0, busy}, 64'd0);
    do_start();
    wait_done("after_rst", 1000);
    check_results("after_rst", 32'd80, 32'd112, 32'd48, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
